block_loader: RTL and testbench
===============================

# block_loader

Host-side writer for the block memory's loader port. Accepts a load command (base address, block count) plus a stream of host words over a valid/ready handshake. Packs each group of BLOCKWORDS words into one block. Issues one single-cycle `loader_write_valid` beat per block, with auto-incrementing block addresses. Sits between the host DMA/stream interface and the block memory, and is the only driver of the memory's loader write port.

## Interface
- BITWIDTH, 16, word and address width
- MESHUNITS, 2, mesh dimension
- TILEUNITS, 2, tile dimension
- ADDRSIZE, 256, block memory depth in words
- BLOCKWORDS (localparam), MESHUNITS*MESHUNITS*TILEUNITS*TILEUNITS, words per block

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_base_addr  in  BITWIDTH  first block word address
- cmd_num_blocks  in  BITWIDTH  number of blocks to load
- in_valid  in  1  host word offered
- in_ready  out  1  host word accepted when both high
- in_data  in  BITWIDTH  host word
- loader_write_addr  out  BITWIDTH  block base address
- loader_write_valid  out  1  one-cycle write strobe
- loader_write_data  out  BLOCKWORDS x BITWIDTH  packed block; element 0 is at the lowest address
- busy  out  1  command in progress
- done  out  1  one-cycle pulse when a command completes
- err  out  1  one-cycle pulse when a command is rejected

## Operation
- States: IDLE, FILL, WRITE.
- IDLE:
  - cmd_ready=1; all other outputs 0 except data, which holds.
  - On cmd handshake with num_blocks==0: done pulses next cycle; stay in IDLE.
  - Reject the command if either condition holds:
    - base misaligned: low log2(BLOCKWORDS) bits nonzero.
    - base + num_blocks*BLOCKWORDS > ADDRSIZE, computed in 2*BITWIDTH bits so it cannot wrap.
  - On rejection: err pulses next cycle, no writes, stay in IDLE.
  - Otherwise latch cur_addr=base and blocks_left=num_blocks, then go to FILL.
- FILL:
  - in_ready=1, busy=1.
  - Each in handshake stores in_data at buffer[idx] and increments idx.
  - The handshake at idx==BLOCKWORDS-1 resets idx to 0 and moves to WRITE.
  - in_valid gaps stall with no side effects.
- WRITE (one cycle):
  - loader_write_valid=1, loader_write_addr=cur_addr, in_ready=0.
  - Next: cur_addr+=BLOCKWORDS and blocks_left-=1.
  - If blocks_left becomes 0: done pulses and go to IDLE. Else go to FILL.
- cmd_valid while busy is ignored (cmd_ready=0).
- Data is treated as raw bits, with no sign handling.

## Timing
- Reset values: cmd_ready=1; in_ready=0; loader_write_valid=0; loader_write_addr=0; loader_write_data all 0; busy=0; done=0; err=0; idx=0.
- Reset asserted mid-command clears everything immediately. The partial block is discarded and no write is issued.
- Latency:
  - Last word accepted at cycle N → loader_write_valid at N+1.
  - done at N+2 for the final block.
  - Command accepted at cycle C → in_ready high at C+1.
- Without the double-buffer feature, each block costs BLOCKWORDS+1 cycles (one bubble per block).
- All outputs are registered.

## Configuration
- BLOCK_LOADER_DOUBLEBUF_EN:
  - Defined:
    - Two buffers, ping-pong.
    - In the WRITE cycle in_ready stays 1 and words go into the alternate buffer.
    - Sustained throughput is 1 word/cycle with no bubble.
    - loader_write_data is driven from the just-filled buffer and stable during the strobe.
    - On the final block in_ready=0 during WRITE.
  - Undefined: single buffer, in_ready=0 in WRITE, as described above.

## Structure
- Shared package:
  - state enum (IDLE/FILL/WRITE)
  - BLOCKWORDS and log2 helper function
  - alignment-mask helper (shared with the block memory's address masking)
- One natural sub-module: block_pack_buffer. It holds the word-indexed write buffer, the index counter and the full flag; two instances are used under BLOCK_LOADER_DOUBLEBUF_EN.

## Test plan
- Single block: base 0, num 1, words 1..16 streamed back to back → one write strobe, addr 0, data[i]=i+1; done the following cycle.
- Two blocks at base 16, random in_valid gaps → writes at addr 16 then 32 with correct data, and in_ready=0 in each WRITE cycle. With DOUBLEBUF_EN the words continue with no bubble.
- Misaligned base 5, num 1 → err pulse; no loader_write_valid; cmd_ready high the next cycle.
- Range overflow: base 240, num 2, ADDRSIZE 256 → err pulse, no writes. Base 240, num 1 → accepted, write at addr 240.
- num_blocks 0 → done pulse, no in_ready, no write.
- Reset asserted low after 7 words of a block → all outputs at reset values immediately. A new command for base 0 then fills from idx 0, and the first write carries only new words.

Source files
------------

// File: rtl/block_loader_pkg.sv
// block_loader_pkg: shared state type and sizing helpers for the block loader and block memory.
package block_loader_pkg;
    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    function automatic int block_words(input int mesh, input int tile);
        return mesh * mesh * tile * tile;
    endfunction

    function automatic int log2c(input int v);
        int r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Low-bit mask of a block-aligned word address.
    function automatic int align_mask(input int words);
        return words - 1;
    endfunction
endpackage

// File: rtl/block_pack_buffer.sv
// block_pack_buffer: word-indexed block buffer with fill index and full flag.
module block_pack_buffer
    import block_loader_pkg::*;
#(
    parameter int W = 16,
    parameter int N = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_wr,
    input  logic                i_rel,
    input  logic [W-1:0]        i_data,
    output logic [N-1:0][W-1:0] o_data,
    output logic                o_last,
    output logic                o_full
);
    localparam int IW = log2c(N);

    logic [IW-1:0] r_idx;

    assign o_last = i_wr && r_idx == IW'(N - 1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            o_data <= '0;
            r_idx  <= '0;
            o_full <= 1'b0;
        end else begin
            if (i_wr) begin
                o_data[r_idx] <= i_data;
                r_idx         <= o_last ? '0 : r_idx + 1'b1;
            end
            o_full <= o_last ? 1'b1 : (i_rel ? 1'b0 : o_full);
        end
    end
endmodule

// File: rtl/block_loader.sv
// block_loader: packs host words into blocks and drives the block memory loader port.
// Define BLOCK_LOADER_DOUBLEBUF_EN for ping-pong buffering without the per-block bubble.
module block_loader
    import block_loader_pkg::*;
#(
    parameter  int BITWIDTH   = 16,
    parameter  int MESHUNITS  = 2,
    parameter  int TILEUNITS  = 2,
    parameter  int ADDRSIZE   = 256,
    localparam int BLOCKWORDS = block_words(MESHUNITS, TILEUNITS)
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic [BITWIDTH-1:0]                  cmd_base_addr,
    input  logic [BITWIDTH-1:0]                  cmd_num_blocks,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [BITWIDTH-1:0]                  in_data,
    output logic [BITWIDTH-1:0]                  loader_write_addr,
    output logic                                 loader_write_valid,
    output logic [BLOCKWORDS-1:0][BITWIDTH-1:0]  loader_write_data,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err
);
    localparam int AW2 = 2 * BITWIDTH;
    localparam logic [BITWIDTH-1:0] MASK = BITWIDTH'(align_mask(BLOCKWORDS));
`ifdef BLOCK_LOADER_DOUBLEBUF_EN
    localparam bit DOUBLEBUF = 1'b1;
`else
    localparam bit DOUBLEBUF = 1'b0;
`endif

    state_t              r_state;
    logic [BITWIDTH-1:0] r_cur_addr;
    logic [BITWIDTH-1:0] r_left;
    logic                w_fire;
    logic                w_last;
    logic                w_full;
    logic                w_bad;
    logic [AW2-1:0]      w_end;

    // Range end computed double-width so a huge block count cannot wrap past the check.
    assign w_end  = AW2'(cmd_base_addr) + AW2'(cmd_num_blocks) * AW2'(BLOCKWORDS);
    assign w_bad  = (cmd_base_addr & MASK) != '0 || w_end > AW2'(ADDRSIZE);
    assign w_fire = in_valid && in_ready && !w_full;

`ifdef BLOCK_LOADER_DOUBLEBUF_EN
    logic                                r_wr_sel;
    logic                                r_rd_sel;
    logic [1:0]                          w_last_b;
    logic [1:0]                          w_full_b;
    logic [BLOCKWORDS-1:0][BITWIDTH-1:0] w_data_b [2];

    for (genvar b = 0; b < 2; b++) begin : g_buf
        block_pack_buffer #(.W(BITWIDTH), .N(BLOCKWORDS)) u_buf (
            .clock  (clock),
            .reset  (reset),
            .i_wr   (w_fire && r_wr_sel == 1'(b)),
            .i_rel  (r_state == WRITE && r_rd_sel == 1'(b)),
            .i_data (in_data),
            .o_data (w_data_b[b]),
            .o_last (w_last_b[b]),
            .o_full (w_full_b[b])
        );
    end

    assign w_last            = |w_last_b;
    assign w_full            = w_full_b[r_wr_sel];
    assign loader_write_data = w_data_b[r_rd_sel];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
        end else if (w_last) begin
            r_wr_sel <= ~r_wr_sel;
            r_rd_sel <= r_wr_sel;
        end
    end
`else
    block_pack_buffer #(.W(BITWIDTH), .N(BLOCKWORDS)) u_buf (
        .clock  (clock),
        .reset  (reset),
        .i_wr   (w_fire),
        .i_rel  (r_state == WRITE),
        .i_data (in_data),
        .o_data (loader_write_data),
        .o_last (w_last),
        .o_full (w_full)
    );
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state            <= IDLE;
            r_cur_addr         <= '0;
            r_left             <= '0;
            cmd_ready          <= 1'b1;
            in_ready           <= 1'b0;
            loader_write_valid <= 1'b0;
            loader_write_addr  <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            err                <= 1'b0;
        end else begin
            done               <= 1'b0;
            err                <= 1'b0;
            loader_write_valid <= 1'b0;
            loader_write_addr  <= '0;
            case (r_state)
                IDLE: if (cmd_valid) begin
                    if (cmd_num_blocks == '0) done <= 1'b1;
                    else if (w_bad) err <= 1'b1;
                    else begin
                        r_state    <= FILL;
                        r_cur_addr <= cmd_base_addr;
                        r_left     <= cmd_num_blocks;
                        cmd_ready  <= 1'b0;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                FILL: if (w_last) begin
                    r_state            <= WRITE;
                    loader_write_valid <= 1'b1;
                    loader_write_addr  <= r_cur_addr;
                    in_ready           <= DOUBLEBUF && r_left != BITWIDTH'(1);
                end
                WRITE: begin
                    r_cur_addr <= r_cur_addr + BITWIDTH'(BLOCKWORDS);
                    r_left     <= r_left - 1'b1;
                    if (r_left == BITWIDTH'(1)) begin
                        r_state   <= IDLE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        in_ready  <= 1'b0;
                    end else begin
                        r_state  <= FILL;
                        in_ready <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_block_loader.sv
// tb_block_loader: randomized bench for block_loader against a command-level reference model.
`timescale 1ns/1ps
module tb_block_loader;
    localparam int W = 16, BW = 16, ASIZE = 256;
    typedef logic [BW-1:0][W-1:0] blk_t;

    logic         clock = 1'b0, reset = 1'b0, cmd_valid = 1'b0, in_valid = 1'b0;
    logic [W-1:0] cmd_base_addr = '0, cmd_num_blocks = '0, in_data = '0;
    logic         cmd_ready, in_ready, loader_write_valid, busy, done, err;
    logic [W-1:0] loader_write_addr;
    blk_t         loader_write_data;

    int checks = 0, failures = 0;
    int got_done = 0, got_err = 0, n_wr = 0;
    int exp_done = 0, exp_err = 0, exp_wr = 0;
    logic [W-1:0] exp_addr_q[$];
    blk_t         exp_data_q[$];

    always #5 clock = ~clock;

    block_loader dut (
        .clock              (clock),
        .reset              (reset),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_base_addr      (cmd_base_addr),
        .cmd_num_blocks     (cmd_num_blocks),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_data            (in_data),
        .loader_write_addr  (loader_write_addr),
        .loader_write_valid (loader_write_valid),
        .loader_write_data  (loader_write_data),
        .busy               (busy),
        .done               (done),
        .err                (err)
    );

    task automatic check(input string tag, input logic [BW*W-1:0] got, input logic [BW*W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (done) got_done++;
        if (err) got_err++;
        if (loader_write_valid) begin
            n_wr++;
            if (exp_addr_q.size() == 0) check("wr_unexpected", exp_addr_q.size(), 1);
            else begin
                check("wr_addr", loader_write_addr, exp_addr_q.pop_front());
                check("wr_data", loader_write_data, exp_data_q.pop_front());
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_wv"}, loader_write_valid, 0);
        check({tag, "_waddr"}, loader_write_addr, 0);
        check({tag, "_wdata"}, loader_write_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic offer(input logic [W-1:0] w, input int gap);
        in_valid = 1'b0;
        if ($urandom_range(99) < gap) repeat ($urandom_range(3, 1)) begin
            @(posedge clock); #1;
        end
        in_valid = 1'b1;
        in_data  = w;
        for (int t = 0; t < 40 && !in_ready; t++) begin
            @(posedge clock); #1;
        end
        check("in_ready", in_ready, 1);
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_cmd(input int base, input int num, input int gap, input bit seq);
        bit   ok;
        blk_t blk;
        ok = (base % BW == 0) && (base + num * BW <= ASIZE);
        check("cmd_ready", cmd_ready, 1);
        cmd_valid      = 1'b1;
        cmd_base_addr  = W'(base);
        cmd_num_blocks = W'(num);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        check("done_zero", done, num == 0);
        check("err", err, num != 0 && !ok);
        check("in_ready_acc", in_ready, num != 0 && ok);
        check("busy_acc", busy, num != 0 && ok);
        if (num == 0) exp_done++;
        else if (!ok) exp_err++;
        else begin
            for (int b = 0; b < num; b++) begin
                for (int i = 0; i < BW; i++) blk[i] = seq ? W'(i + 1) : W'($urandom);
                exp_addr_q.push_back(W'(base + b * BW));
                exp_data_q.push_back(blk);
                exp_wr++;
                for (int i = 0; i < BW; i++) offer(blk[i], gap);
                check("wv_latency", loader_write_valid, 1);
`ifdef BLOCK_LOADER_DOUBLEBUF_EN
                check("in_ready_write", in_ready, b != num - 1);
`else
                check("in_ready_write", in_ready, 0);
`endif
            end
            @(posedge clock); #1;
            check("done_latency", done, 1);
            check("busy_end", busy, 0);
            exp_done++;
        end
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check_reset_vals("rst");
        reset = 1'b1;
        @(posedge clock); #1;

        run_cmd(0, 1, 0, 1);
        run_cmd(16, 2, 40, 0);
        run_cmd(5, 1, 0, 0);
        check("cmd_ready_after_err", cmd_ready, 1);
        run_cmd(240, 2, 0, 0);
        run_cmd(240, 1, 20, 0);
        run_cmd(32, 0, 0, 0);
        check("in_ready_zero", in_ready, 0);

        repeat (10) begin
            int base, num;
            base = ($urandom_range(3) == 0) ? int'($urandom_range(255)) : int'($urandom_range(16)) * BW;
            num  = $urandom_range(3);
            run_cmd(base, num, 30, 0);
            repeat ($urandom_range(2)) begin
                @(posedge clock); #1;
            end
        end

        cmd_valid      = 1'b1;
        cmd_base_addr  = '0;
        cmd_num_blocks = W'(1);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 7; i++) offer(W'($urandom), 0);
        reset = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        run_cmd(0, 1, 20, 0);

        repeat (3) @(posedge clock);
        #1;
        check("write_count", n_wr, exp_wr);
        check("done_count", got_done, exp_done);
        check("err_count", got_err, exp_err);
        check("queue_empty", exp_addr_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
